vram_slot_arbiter: RTL

- Time-slot arbiter sharing the single video RAM between the video fetch clients (playfield, motion object, alphanumerics) and the CPU.
- Slot ownership comes from the VRAC code produced by the system clock generator; one slot equals one MCKR period.
- Runs entirely in the clk100 domain, using a one-cycle MCKR strobe as the slot clock enable.
- Issues one RAM access per slot, returns read data to the owning client and handshakes CPU requests.

---
 rtl/vram_slot_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/vram_slot_arbiter.sv
// Time-slot arbiter sharing one video RAM between the video fetch clients and the CPU.
// One access is issued per MCKR slot, and its read data is returned to the client that owns the slot.
module vram_slot_arbiter #(
  parameter int AW       = 14,
  parameter int DW       = 16,
  parameter int RD_LAT   = 2,
  parameter int MAX_WAIT = 64
) (
  input  logic          clk100,
  input  logic          rst,
  input  logic          mckr_en,
  input  logic [2:0]    vrac,
  input  logic [AW-1:0] pf_addr,
  input  logic [AW-1:0] mo_addr,
  input  logic [AW-1:0] an_addr,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          vid_valid,
  output logic [1:0]    vid_client,
  output logic [DW-1:0] vid_data,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          cpu_starve
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int             LCW       = 4;
  localparam logic [LCW-1:0] LAT_INIT  = LCW'(RD_LAT);
  localparam int             WCW       = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX  = WCW'(MAX_WAIT);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);

  logic [1:0]     state;
  logic           req_we;
  logic [AW-1:0]  req_addr;
  logic [DW-1:0]  req_wdata;
  logic [WCW-1:0] wait_cnt;

  logic           busy;
  logic [LCW-1:0] lat_cnt;
  logic           fl_cpu;
  logic           fl_we;
  logic [1:0]     fl_client;

  logic           slot_video;
  logic [1:0]     slot_client;
  logic [AW-1:0]  video_addr;
  logic           slot_take;
  logic           cpu_grant;
  logic           complete;

  // Codes 3..7 and unknown codes all fall to the default branch and count as free slots.
  always_comb begin
    slot_video  = 1'b0;
    slot_client = 2'd0;
    video_addr  = pf_addr;
    case (vrac)
      3'd0: begin slot_video = 1'b1; slot_client = 2'd0; video_addr = pf_addr; end
      3'd1: begin slot_video = 1'b1; slot_client = 2'd1; video_addr = mo_addr; end
      3'd2: begin slot_video = 1'b1; slot_client = 2'd2; video_addr = an_addr; end
      default: ;
    endcase
  end

  assign slot_take = mckr_en && !busy;
  assign cpu_grant = slot_take && !slot_video && (state == S_WAIT) && cpu_req;
  assign complete  = busy && (lat_cnt == '0);

  // Single in-flight access: issue, count down the read latency, then steer the data.
  always_ff @(posedge clk100) begin
    if (rst) begin
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      vid_valid  <= 1'b0;
      vid_client <= 2'd0;
      vid_data   <= '0;
      cpu_ack    <= 1'b0;
      cpu_rdata  <= '0;
      busy       <= 1'b0;
      lat_cnt    <= '0;
      fl_cpu     <= 1'b0;
      fl_we      <= 1'b0;
      fl_client  <= 2'd0;
    end else begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      vid_valid <= 1'b0;
      cpu_ack   <= 1'b0;
      if (slot_take && slot_video) begin
        ram_en    <= 1'b1;
        ram_addr  <= video_addr;
        busy      <= 1'b1;
        lat_cnt   <= LAT_INIT;
        fl_cpu    <= 1'b0;
        fl_we     <= 1'b0;
        fl_client <= slot_client;
      end else if (cpu_grant) begin
        ram_en   <= 1'b1;
        ram_we   <= req_we;
        ram_addr <= req_addr;
        if (req_we) ram_wdata <= req_wdata;
        busy     <= 1'b1;
        lat_cnt  <= LAT_INIT;
        fl_cpu   <= 1'b1;
        fl_we    <= req_we;
      end else if (complete) begin
        busy <= 1'b0;
        if (fl_cpu) begin
          cpu_ack <= 1'b1;
          if (!fl_we) cpu_rdata <= ram_rdata;
        end else begin
          vid_valid  <= 1'b1;
          vid_client <= fl_client;
          vid_data   <= ram_rdata;
        end
      end else if (busy) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
    end
  end

  // CPU request FSM; the wait counter only advances on video slots seen while waiting.
  always_ff @(posedge clk100) begin
    if (rst) begin
      state      <= S_IDLE;
      req_we     <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
      wait_cnt   <= '0;
      cpu_starve <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            req_we    <= cpu_we;
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
            wait_cnt  <= '0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!cpu_req) begin
            state <= S_IDLE;
          end else if (cpu_grant) begin
            state <= S_ISSUE;
          end else if (mckr_en && slot_video && (wait_cnt != WAIT_MAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == WAIT_LAST) cpu_starve <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (complete && fl_cpu) state <= S_DONE;
        end
        S_DONE: begin
          if (!cpu_req) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
